// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into one-cycle event pulses:
// press/release edges, single click, double click, long press and auto-repeat.
module button_event_classifier #(
  parameter int LONG_CYCLES   = 8,
  parameter int DOUBLE_GAP    = 4,
  parameter int REPEAT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int MAX_AB = (LONG_CYCLES > DOUBLE_GAP) ? LONG_CYCLES : DOUBLE_GAP;
  localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1) + 1;

  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] GAP_C  = CW'(DOUBLE_GAP);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam bit            REP_EN = (REPEAT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          r_in_ff;
  logic          w_rise;
  logic          w_fall;

  logic r_press, r_release, r_click, r_double, r_long, r_repeat, r_busy;
  logic w_click_next, w_double_next, w_long_next, w_repeat_next;

  assign w_rise    = signal_in & ~r_in_ff;
  assign w_fall    = ~signal_in & r_in_ff;
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + ONE_C;

  // State register; every output is registered here alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_in_ff   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_in_ff   <= signal_in;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_click   <= w_click_next;
      r_double  <= w_double_next;
      r_long    <= w_long_next;
      r_repeat  <= w_repeat_next;
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_next = S_PRESS1;
          w_cnt_next   = ONE_C;
        end
      end
      S_PRESS1, S_PRESS2: begin
        if (signal_in) begin
          if (w_cnt_inc == LONG_C) begin
            w_state_next = S_LONG;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else if (r_state == S_PRESS1) begin
          w_state_next = S_WAIT2;
          w_cnt_next   = ONE_C;
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      S_WAIT2: begin
        if (signal_in) begin
          w_state_next = S_PRESS2;
          w_cnt_next   = ONE_C;
        end else if (w_cnt_inc == GAP_C) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_LONG: begin
        if (!signal_in) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (REP_EN && (w_cnt_inc == REP_C)) begin
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Classified event decode; at most one of these can be set per cycle.
  always_comb begin
    w_click_next  = 1'b0;
    w_double_next = 1'b0;
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    case (r_state)
      S_PRESS1: w_long_next = signal_in && (w_cnt_inc == LONG_C);
      S_PRESS2: begin
        w_long_next   = signal_in && (w_cnt_inc == LONG_C);
        w_double_next = ~signal_in;
      end
      S_WAIT2:  w_click_next  = ~signal_in && (w_cnt_inc == GAP_C);
      S_LONG:   w_repeat_next = signal_in && REP_EN && (w_cnt_inc == REP_C);
      default: ;
    endcase
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click         = r_click;
  assign double_click  = r_double;
  assign long_press    = r_long;
  assign repeat_pulse  = r_repeat;
  assign busy          = r_busy;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed, table-driven check of button_event_classifier with default parameters.
module tb_button_event_classifier;

  logic clk;
  logic rst;
  logic signal_in;
  logic press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, busy;

  int checks = 0;
  int errors = 0;

  // Expected vector bit order: {press, release, click, double, long, repeat, busy}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] PB = 7'b1000001;
  localparam logic [6:0] B  = 7'b0000001;
  localparam logic [6:0] RB = 7'b0100001;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] C  = 7'b0010000;
  localparam logic [6:0] RD = 7'b0101000;
  localparam logic [6:0] LB = 7'b0000101;
  localparam logic [6:0] QB = 7'b0000011;

  typedef struct {
    logic       rst_v;
    logic       sig;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  button_event_classifier #(
    .LONG_CYCLES(8), .DOUBLE_GAP(4), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .click(click), .double_click(double_click),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [6:0] e, input string t);
    vec_t v;
    v.rst_v = r; v.sig = s; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic s, input logic [6:0] e, input string t, input int idx);
    logic [6:0] act;
    int n_ev;
    @(negedge clk);
    rst = r;
    signal_in = s;
    @(posedge clk);
    #1;
    act = {press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, busy};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s[%0d] outputs got %b expected %b", t, idx, act, e);
    end else begin
      $display("ok   %s[%0d] rst=%0b in=%0b outputs %b", t, idx, r, s, act);
    end
    n_ev = int'(click) + int'(double_click) + int'(long_press) + int'(repeat_pulse);
    checks++;
    if (n_ev > 1) begin
      errors++;
      $display("FAIL excl %s[%0d] event pulses high got %0d expected <=1", t, idx, n_ev);
    end
  endtask

  initial begin
    rst = 1'b1;
    signal_in = 1'b0;

    // Reset with button held, then single click (3 highs).
    add(1, 1, Z, "reset"); add(1, 1, Z, "reset"); add(1, 1, Z, "reset");
    add(0, 1, PB, "click"); add(0, 1, B, "click"); add(0, 1, B, "click");
    add(0, 0, RB, "click"); add(0, 0, B, "click"); add(0, 0, B, "click");
    add(0, 0, C, "click"); add(0, 0, Z, "click");
    // Double click: high 2, low 2, high 2, low.
    add(0, 1, PB, "dbl"); add(0, 1, B, "dbl"); add(0, 0, RB, "dbl"); add(0, 0, B, "dbl");
    add(0, 1, PB, "dbl"); add(0, 1, B, "dbl"); add(0, 0, RD, "dbl"); add(0, 0, Z, "dbl");
    // 7 highs: still a short press, ends in click.
    add(0, 1, PB, "hi7");
    for (int i = 0; i < 6; i++) add(0, 1, B, "hi7");
    add(0, 0, RB, "hi7"); add(0, 0, B, "hi7"); add(0, 0, B, "hi7");
    add(0, 0, C, "hi7"); add(0, 0, Z, "hi7");
    // 8 highs: long press at the 8th sample.
    add(0, 1, PB, "hi8");
    for (int i = 0; i < 6; i++) add(0, 1, B, "hi8");
    add(0, 1, LB, "hi8"); add(0, 0, R, "hi8"); add(0, 0, Z, "hi8");
    // Gap of 3 lows still double-clicks.
    add(0, 1, PB, "gap3"); add(0, 0, RB, "gap3"); add(0, 0, B, "gap3"); add(0, 0, B, "gap3");
    add(0, 1, PB, "gap3"); add(0, 0, RD, "gap3"); add(0, 0, Z, "gap3");
    // Gap of 4 lows clicks; following presses start fresh, third press is a new PRESS1.
    add(0, 1, PB, "gap4"); add(0, 0, RB, "gap4"); add(0, 0, B, "gap4"); add(0, 0, B, "gap4");
    add(0, 0, C, "gap4"); add(0, 1, PB, "gap4"); add(0, 0, RB, "gap4"); add(0, 1, PB, "gap4");
    add(0, 0, RD, "gap4"); add(0, 1, PB, "gap4"); add(0, 0, RB, "gap4"); add(0, 0, B, "gap4");
    add(0, 0, B, "gap4"); add(0, 0, C, "gap4"); add(0, 0, Z, "gap4");
    // Second press held to LONG_CYCLES gives long_press, no double_click.
    add(0, 1, PB, "p2long"); add(0, 0, RB, "p2long"); add(0, 1, PB, "p2long");
    for (int i = 0; i < 6; i++) add(0, 1, B, "p2long");
    add(0, 1, LB, "p2long"); add(0, 0, R, "p2long"); add(0, 0, Z, "p2long");

    foreach (vecs[i]) step(vecs[i].rst_v, vecs[i].sig, vecs[i].exp, vecs[i].tag, i);

    // Long hold of 20 samples with auto-repeat every 3.
    for (int i = 0; i < 20; i++) begin
      logic [6:0] e;
      if (i == 0)                          e = PB;
      else if (i == 7)                     e = LB;
      else if (i >= 10 && (i - 7) % 3 == 0) e = QB;
      else                                 e = B;
      step(0, 1, e, "hold", i);
    end
    step(0, 0, R, "hold_rel", 0);
    step(0, 0, Z, "hold_rel", 1);

    // Reset during WAIT2 suppresses the pending click.
    step(0, 1, PB, "midrst", 0);
    step(0, 0, RB, "midrst", 1);
    step(0, 0, B,  "midrst", 2);
    step(1, 0, Z,  "midrst", 3);
    step(0, 0, Z,  "midrst", 4);
    step(0, 0, Z,  "midrst", 5);
    step(0, 0, Z,  "midrst", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
